// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: sizes, FSM state type and the
// constant jump/branch target tables indexed by the decoder's 4-bit field.
package fetch_unit_pkg;

  localparam int PC_W  = 10;
  localparam int IDX_W = 4;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  // Absolute jump destinations.
  function automatic logic [PC_W-1:0] jump_lut(input logic [IDX_W-1:0] idx);
    logic [PC_W-1:0] t;
    case (idx)
      4'd0:    t = 10'h000;
      4'd1:    t = 10'h040;
      4'd2:    t = 10'h080;
      4'd3:    t = 10'h100;
      4'd4:    t = 10'h180;
      4'd5:    t = 10'h200;
      4'd6:    t = 10'h280;
      4'd7:    t = 10'h300;
      4'd8:    t = 10'h3F0;
      4'd9:    t = 10'h010;
      4'd10:   t = 10'h020;
      4'd11:   t = 10'h3FF;
      4'd12:   t = 10'h155;
      4'd13:   t = 10'h2AA;
      4'd14:   t = 10'h0C0;
      4'd15:   t = 10'h1C0;
      default: t = 10'h000;
    endcase
    return t;
  endfunction

  // Signed PC-relative branch offsets, sign-extended by the consumer.
  function automatic logic signed [7:0] branch_lut(input logic [IDX_W-1:0] idx);
    logic signed [7:0] o;
    case (idx)
      4'd0:    o = 8'sd1;
      4'd1:    o = 8'sd2;
      4'd2:    o = 8'sd4;
      4'd3:    o = 8'sd8;
      4'd4:    o = -8'sd1;
      4'd5:    o = -8'sd4;
      4'd6:    o = -8'sd8;
      4'd7:    o = -8'sd16;
      4'd8:    o = 8'sd16;
      4'd9:    o = 8'sd32;
      4'd10:   o = -8'sd32;
      4'd11:   o = 8'sd127;
      4'd12:   o = -8'sd128;
      4'd13:   o = 8'sd64;
      4'd14:   o = -8'sd64;
      4'd15:   o = -8'sd2;
      default: o = 8'sd0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fetch_unit_target_lut.sv
// Combinational lookup of the jump target and the PC-width sign-extended
// branch offset for the decoder-supplied table index.
module target_lut
  import fetch_unit_pkg::*;
(
  input  logic [IDX_W-1:0] target_idx,
  output logic [PC_W-1:0]  jump_target,
  output logic [PC_W-1:0]  branch_offset
);

  logic signed [7:0] off_s;

  always_comb begin
    off_s         = branch_lut(target_idx);
    jump_target   = jump_lut(target_idx);
    branch_offset = {{(PC_W-8){off_s[7]}}, off_s};
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and start/run/halt sequencer feeding the instruction ROM,
// with a saturating counter of cycles spent in RUN since the last start.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Halt,
  input  logic             jump_en,
  input  logic             branch_en,
  input  logic [IDX_W-1:0] target_idx,
  output logic [PC_W-1:0]  PC,
  output logic             Done,
  output logic             Running,
  output logic [CNT_W-1:0] cycle_count
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             done_q, done_d;
  logic             running_q, running_d;
  logic [PC_W-1:0]  jump_target, branch_offset;

  target_lut u_lut (
    .target_idx    (target_idx),
    .jump_target   (jump_target),
    .branch_offset (branch_offset)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_ARMED;
          pc_d    = StartAddr;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        if (Start) begin
          pc_d = StartAddr;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A restart clears the counter; every other RUN cycle is counted.
        if (Start) begin
          state_d = ST_ARMED;
          pc_d    = StartAddr;
          cnt_d   = '0;
        end else if (Halt) begin
          state_d = ST_HALTED;
          cnt_d   = cnt_inc;
        end else if (jump_en) begin
          pc_d  = jump_target;
          cnt_d = cnt_inc;
        end else if (branch_en) begin
          pc_d  = pc_q + branch_offset;
          cnt_d = cnt_inc;
        end else begin
          pc_d  = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          cnt_d = cnt_inc;
        end
      end
      ST_HALTED: begin
        if (Start) begin
          state_d = ST_ARMED;
          pc_d    = StartAddr;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
    done_d    = (state_d == ST_HALTED);
    running_d = (state_d == ST_RUN);
  end

  assign PC          = pc_q;
  assign Done        = done_q;
  assign Running     = running_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit, checked against a
// behavioural model of the start/run/halt sequencing kept in the bench.
module tb_fetch_unit;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [9:0] StartAddr = 10'h000;
  logic       Halt = 1'b0;
  logic       jump_en = 1'b0;
  logic       branch_en = 1'b0;
  logic [3:0] target_idx = 4'h0;
  logic [9:0] PC;
  logic       Done;
  logic       Running;
  logic [15:0] cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0=idle 1=armed 2=running 3=halted; plain integer PC/count.
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;
  int jmp_tab [16] = '{'h000, 'h040, 'h080, 'h100, 'h180, 'h200, 'h280, 'h300,
                       'h3F0, 'h010, 'h020, 'h3FF, 'h155, 'h2AA, 'h0C0, 'h1C0};
  int br_tab  [16] = '{1, 2, 4, 8, -1, -4, -8, -16, 16, 32, -32, 127, -128, 64, -64, -2};

  fetch_unit dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Start       (Start),
    .StartAddr   (StartAddr),
    .Halt        (Halt),
    .jump_en     (jump_en),
    .branch_en   (branch_en),
    .target_idx  (target_idx),
    .PC          (PC),
    .Done        (Done),
    .Running     (Running),
    .cycle_count (cycle_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (Reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (Start) begin m_mode = 1; m_pc = int'(StartAddr); m_cnt = 0; end
    end else if (m_mode == 1) begin
      if (Start) m_pc = int'(StartAddr);
      else m_mode = 2;
    end else if (m_mode == 2) begin
      if (Start) begin
        m_mode = 1; m_pc = int'(StartAddr); m_cnt = 0;
      end else begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (Halt)           m_mode = 3;
        else if (jump_en)   m_pc = jmp_tab[target_idx];
        else if (branch_en) m_pc = (m_pc + br_tab[target_idx] + 1024) % 1024;
        else                m_pc = (m_pc + 1) % 1024;
      end
    end else begin
      if (Start) begin m_mode = 1; m_pc = int'(StartAddr); m_cnt = 0; end
    end
  endtask

  task automatic cyc(input logic rst, input logic st, input logic [9:0] sa,
                     input logic h, input logic j, input logic b,
                     input logic [3:0] idx, input bit do_chk, input string tag);
    @(negedge CLK);
    Reset = rst; Start = st; StartAddr = sa; Halt = h;
    jump_en = j; branch_en = b; target_idx = idx;
    @(posedge CLK);
    model_step();
    #1;
    if (do_chk) begin
      chk({tag, ".pc"},   int'(PC), m_pc);
      chk({tag, ".done"}, int'(Done), (m_mode == 3) ? 1 : 0);
      chk({tag, ".run"},  int'(Running), (m_mode == 2) ? 1 : 0);
      chk({tag, ".cnt"},  int'(cycle_count), m_cnt);
    end
  endtask

  task automatic idle_cyc(input bit do_chk, input string tag);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 4'h0, do_chk, tag);
  endtask

  // Start at sa, release, and leave the DUT at PC=sa in RUN.
  task automatic launch(input logic [9:0] sa, input string tag);
    cyc(1'b0, 1'b1, sa, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, tag);
    idle_cyc(1'b1, tag);
  endtask

  initial begin
    // Reset
    cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "rst0");
    cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "rst1");
    chk("rst.pc_const", int'(PC), 0);

    // Start and step; decoder inputs ignored while armed
    cyc(1'b0, 1'b1, 10'h020, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1, "arm0");
    cyc(1'b0, 1'b1, 10'h020, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1, "arm1");
    cyc(1'b0, 1'b1, 10'h020, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "arm2");
    idle_cyc(1'b1, "go");
    chk("go.pc_020", int'(PC), 'h020);
    for (int i = 0; i < 3; i++) idle_cyc(1'b1, "step");
    chk("step.pc_023", int'(PC), 'h023);
    chk("step.cnt_3", int'(cycle_count), 3);

    // Jump beats branch
    launch(10'h030, "jb_launch");
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, "jump");
    chk("jump.pc_100", int'(PC), 'h100);

    // Backward branch with wrap, then without
    launch(10'h002, "br_launch");
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1, "brwrap");
    chk("brwrap.pc_3fe", int'(PC), 'h3FE);
    launch(10'h050, "br2_launch");
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1, "br");
    chk("br.pc_04c", int'(PC), 'h04C);

    // Halt, hold, restart
    launch(10'h044, "halt_launch");
    cyc(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, "halt");
    chk("halt.done", int'(Done), 1);
    chk("halt.cnt_1", int'(cycle_count), 1);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1, "hold");
    chk("hold.pc_044", int'(PC), 'h044);
    cyc(1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "restart");
    chk("restart.done0", int'(Done), 0);

    // PC wrap, mid-run Start, Reset overriding Start
    launch(10'h3FF, "wrap_launch");
    idle_cyc(1'b1, "wrap");
    chk("wrap.pc_000", int'(PC), 0);
    cyc(1'b0, 1'b1, 10'h080, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "midstart");
    chk("midstart.pc_080", int'(PC), 'h080);
    idle_cyc(1'b1, "midstart_go");
    idle_cyc(1'b1, "midstart_run");
    cyc(1'b1, 1'b1, 10'h155, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "rst_start");
    chk("rst_start.pc0", int'(PC), 0);

    // Counter saturation
    launch(10'h000, "sat_launch");
    for (int i = 0; i < 65540; i++) idle_cyc(1'b0, "sat");
    idle_cyc(1'b1, "sat_end");
    chk("sat.cnt_ffff", int'(cycle_count), 'hFFFF);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) == 0),
          10'($urandom_range(0, 1023)), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
          4'($urandom_range(0, 15)), 1'b1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
